// File: rtl/uart_link_tx.sv
// Game-link transmitter: turns READY/SCORE/STOP/PING events into checksummed
// UART 8N1 frames (header, optional 12-bit score payload, XOR checksum).
module uart_link_tx #(
  parameter int CLK_FREQ = 40_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        send_req,
  input  logic [1:0]  msg_type,
  input  logic [11:0] score,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       MSG_SCORE = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [1:0]       r_byte_idx, w_byte_idx_nxt;
  logic [1:0]       r_last_idx;
  logic [7:0]       r_bytes [4];
  logic             r_tx, w_tx_nxt;
  logic             r_done, w_done_nxt;
  logic             w_accept;
  logic             w_bit_end;
  logic [7:0]       w_cur_byte, w_hdr, w_p_hi, w_p_lo;

  assign w_hdr      = 8'hA0 | {6'b0, msg_type};
  assign w_p_hi     = {4'h0, score[11:8]};
  assign w_p_lo     = score[7:0];
  assign w_cur_byte = r_bytes[r_byte_idx];
  assign w_bit_end  = (r_cnt == CNT_LAST);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_tx_nxt       = r_tx;
    w_done_nxt     = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt  = 1'b1;
        w_cnt_nxt = '0;
        if (send_req) begin
          w_accept       = 1'b1;
          w_state_nxt    = S_START;
          w_tx_nxt       = 1'b0;
          w_bit_idx_nxt  = '0;
          w_byte_idx_nxt = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt     = '0;
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = w_cur_byte[0];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt      = w_cur_byte[r_bit_idx + 3'd1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_byte_idx == r_last_idx) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_tx_nxt    = 1'b1;
          end else begin
            // Next byte follows immediately with its start bit.
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_state_nxt    = S_START;
            w_tx_nxt       = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // NOTE: the frame buffer has no reset; it is always rewritten at accept
  // before any byte of it is read.
  always_ff @(posedge pclk) begin
    if (w_accept) begin
      r_bytes[0] <= w_hdr;
      if (msg_type == MSG_SCORE) begin
        r_bytes[1] <= w_p_hi;
        r_bytes[2] <= w_p_lo;
        r_bytes[3] <= w_hdr ^ w_p_hi ^ w_p_lo;
        r_last_idx <= 2'd3;
      end else begin
        r_bytes[1] <= w_hdr;
        r_last_idx <= 2'd1;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign tx   = r_tx;

endmodule

// File: tb/tb_uart_link_tx.sv
// Bench for uart_link_tx: frame-level reference model plus a peer UART
// receiver model; runs at a scaled-down clock so bit time is 17 cycles.
module tb_uart_link_tx;

  localparam int TB_CLK_FREQ = 2_000_000;
  localparam int TB_BAUD     = 115_200;
  localparam int CPB         = TB_CLK_FREQ / TB_BAUD;

  logic        pclk = 1'b0;
  logic        rst;
  logic        send_req;
  logic [1:0]  msg_type;
  logic [11:0] score;
  logic        busy, done, tx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];

  uart_link_tx #(.CLK_FREQ(TB_CLK_FREQ), .BAUD(TB_BAUD)) dut (
    .pclk     (pclk),
    .rst      (rst),
    .send_req (send_req),
    .msg_type (msg_type),
    .score    (score),
    .busy     (busy),
    .done     (done),
    .tx       (tx)
  );

  always #5 pclk = ~pclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: header, SCORE payload, then XOR of everything before.
  task automatic build_frame(input logic [1:0] m, input logic [11:0] s);
    logic [7:0] chk;
    exp_q.delete();
    exp_q.push_back(8'hA0 + {6'b0, m});
    if (m == 2'd1) begin
      exp_q.push_back({4'h0, s[11:8]});
      exp_q.push_back(s[7:0]);
    end
    chk = 8'h00;
    foreach (exp_q[i]) chk = chk ^ exp_q[i];
    exp_q.push_back(chk);
  endtask

  // Peer receiver: detect start, sample mid-bit, collect bytes.
  initial begin : peer_rx
    logic [7:0] b;
    forever begin
      @(negedge pclk);
      if (tx === 1'b0) begin
        repeat (CPB / 2) @(negedge pclk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge pclk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge pclk);
        rx_q.push_back(b);
      end
    end
  end

  // Called at the negedge of cycle 0; returns at the negedge of the done cycle.
  task automatic send_frame(input logic [1:0] m, input logic [11:0] s,
                            input bit hold, input bit mutate);
    int         len;
    int         bad_tx, bad_busy, bad_done;
    int         bp, k;
    logic [7:0] eb, x;
    logic       exp_bit, start_ok;
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    build_frame(m, s);
    len      = exp_q.size() * 10 * CPB;
    send_req = 1'b1;
    msg_type = m;
    score    = s;
    @(posedge pclk);
    for (int c = 1; c <= len; c++) begin
      @(negedge pclk);
      if (!hold) send_req = 1'b0;
      if (mutate && c == len / 3) begin
        msg_type = 2'($urandom_range(0, 3));
        score    = 12'($urandom_range(0, 4095));
      end
      bp = (c - 1) / CPB;
      k  = bp % 10;
      if (k == 0) exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else begin
        eb      = exp_q[bp / 10];
        exp_bit = eb[k-1];
      end
      if (tx !== exp_bit) bad_tx++;
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) bad_done++;
      if (c == 1) check("start_low_c1", tx, 1'b0);
    end
    @(negedge pclk);
    check("frame_tx_errs", bad_tx, 0);
    check("frame_busy_errs", bad_busy, 0);
    check("frame_early_done", bad_done, 0);
    check("done_pulse", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("tx_idle_at_done", tx, 1'b1);
    check("rx_len", rx_q.size(), exp_q.size());
    x = 8'h00;
    foreach (rx_q[i]) begin
      x = x ^ rx_q[i];
      if (i < exp_q.size()) check("rx_byte", rx_q[i], exp_q[i]);
    end
    check("rx_chk_ok", x, 8'h00);
    start_ok = (rx_q.size() > 0) && (rx_q[0] == 8'hA0) && (x == 8'h00);
    check("peer_uart_start", start_ok, (m == 2'd0));
    rx_q.delete();
  endtask

  task automatic after_frame();
    send_req = 1'b0;
    @(negedge pclk);
    check("done_one_cycle", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_tx", tx, 1'b1);
  endtask

  initial begin
    int quiet_bad;
    rst      = 1'b1;
    send_req = 1'b0;
    msg_type = 2'd0;
    score    = 12'd0;
    repeat (3) @(negedge pclk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge pclk);

    send_frame(2'd0, 12'h000, 1'b0, 1'b0);   // READY -> A0,A0
    after_frame();
    send_frame(2'd1, 12'h5C3, 1'b0, 1'b0);   // SCORE -> A1,05,C3,67
    after_frame();

    // Held request: one frame, then a request in the done cycle chains.
    send_frame(2'd0, 12'h000, 1'b1, 1'b0);
    send_frame(2'd3, 12'h000, 1'b1, 1'b0);
    after_frame();

    send_frame(2'd1, 12'hABC, 1'b0, 1'b1);   // inputs change mid-frame
    after_frame();
    send_frame(2'd2, 12'hFFF, 1'b0, 1'b1);
    after_frame();

    // Reset in the middle of DATA of the second SCORE byte.
    send_req = 1'b1;
    msg_type = 2'd1;
    score    = 12'($urandom_range(0, 4095));
    @(posedge pclk);
    @(negedge pclk);
    send_req = 1'b0;
    repeat (13 * CPB) @(negedge pclk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    rst = 1'b0;
    quiet_bad = 0;
    repeat (12 * CPB) begin
      @(negedge pclk);
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) quiet_bad++;
    end
    check("post_rst_quiet", quiet_bad, 0);
    rx_q.delete();
    send_frame(2'd3, 12'h000, 1'b0, 1'b0);   // PING -> A3,A3
    after_frame();

    for (int n = 0; n < 16; n++) begin
      send_frame(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      after_frame();
      repeat ($urandom_range(0, 3)) @(negedge pclk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
